// File: rtl/cache_mem_write_buffer_bridge_if.sv
// Bundle of the cache-side request port and the data_memory command port of
// the write-buffer bridge. The bridge uses the slave view; its environment uses master.
interface cache_mem_write_buffer_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  read_mem;
    logic                  write_mem;
    logic [ADDR_WIDTH-1:0] addr_mem;
    logic [DATA_WIDTH-1:0] wdata_mem;
    logic [DATA_WIDTH-1:0] rdata_mem;
    logic                  ready_mem;
    logic                  mem_rd_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_ready;
    logic                  wbuf_full;
    logic                  wbuf_empty;

    modport slave (
        input  read_mem, write_mem, addr_mem, wdata_mem, mem_rd_data, mem_ready,
        output rdata_mem, ready_mem, mem_rd_en, mem_wr_en, mem_address, mem_wr_data,
               wbuf_full, wbuf_empty
    );

    modport master (
        output read_mem, write_mem, addr_mem, wdata_mem, mem_rd_data, mem_ready,
        input  rdata_mem, ready_mem, mem_rd_en, mem_wr_en, mem_address, mem_wr_data,
               wbuf_full, wbuf_empty
    );
endinterface

// File: rtl/cache_mem_write_buffer_bridge.sv
// Write-buffered bridge from the cache memory port to data_memory: posted writes drain
// in order through a FIFO, reads use a full handshake. Define WBUF_FWD_EN for read forwarding.
module cache_mem_write_buffer_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WBUF_DEPTH = 4
) (
    input logic                            clk,
    input logic                            reset,
    cache_mem_write_buffer_bridge_if.slave bus
);
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD, ST_GAP} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ready_mem_q, ready_mem_d;
    logic [DATA_WIDTH-1:0] rdata_mem_q, rdata_mem_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;

    logic [ADDR_WIDTH-1:0] buf_addr_q [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_q [WBUF_DEPTH];

    logic full, empty, push, pop, rd_req;

    assign full   = (count_q == CNT_W'(WBUF_DEPTH));
    assign empty  = (count_q == '0);
    assign pop    = (state_q == ST_WR) && bus.mem_ready;
    // Requests are ignored while the completion pulse is out, so a held level is not taken twice.
    assign rd_req = bus.read_mem && !bus.write_mem && !ready_mem_q;
    // Blocked in RD so a write acknowledge can never merge with a read completion pulse.
    assign push   = bus.write_mem && !ready_mem_q && (state_q != ST_RD) && (!full || pop);

`ifdef WBUF_FWD_EN
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_take;

    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) &&
                (buf_addr_q[rd_ptr_q + PTR_W'(i)] == bus.addr_mem)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[rd_ptr_q + PTR_W'(i)];
            end
        end
    end

    // A hit needs no memory access, so it is served in any state except an active read.
    assign fwd_take = rd_req && fwd_hit && (state_q != ST_RD);
`endif

    always_comb begin
        state_d       = state_q;
        ready_mem_d   = 1'b0;
        rdata_mem_d   = rdata_mem_q;
        mem_rd_en_d   = mem_rd_en_q;
        mem_wr_en_d   = mem_wr_en_q;
        mem_address_d = mem_address_q;
        mem_wr_data_d = mem_wr_data_q;
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            ST_IDLE: begin
`ifdef WBUF_FWD_EN
                if (fwd_take) begin
                    state_d = ST_IDLE;
                end else if (rd_req) begin
`else
                if (rd_req && empty) begin
`endif
                    state_d       = ST_RD;
                    mem_rd_en_d   = 1'b1;
                    mem_address_d = bus.addr_mem;
                end else if (!empty) begin
                    state_d       = ST_WR;
                    mem_wr_en_d   = 1'b1;
                    mem_address_d = buf_addr_q[rd_ptr_q];
                    mem_wr_data_d = buf_data_q[rd_ptr_q];
                end
            end
            ST_WR: begin
                if (bus.mem_ready) begin
                    mem_wr_en_d = 1'b0;
                    state_d     = ST_GAP;
                end
            end
            ST_RD: begin
                if (bus.mem_ready) begin
                    mem_rd_en_d = 1'b0;
                    rdata_mem_d = bus.mem_rd_data;
                    ready_mem_d = 1'b1;
                    state_d     = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef WBUF_FWD_EN
        if (fwd_take) begin
            rdata_mem_d = fwd_data;
            ready_mem_d = 1'b1;
        end
`endif
        if (push) begin
            ready_mem_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ready_mem_q   <= 1'b0;
            rdata_mem_q   <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ready_mem_q   <= ready_mem_d;
            rdata_mem_q   <= rdata_mem_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_address_q <= mem_address_d;
            mem_wr_data_q <= mem_wr_data_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= bus.addr_mem;
            buf_data_q[wr_ptr_q] <= bus.wdata_mem;
        end
    end

    assign bus.rdata_mem   = rdata_mem_q;
    assign bus.ready_mem   = ready_mem_q;
    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.wbuf_full   = full;
    assign bus.wbuf_empty  = empty;
endmodule
